// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: stage indices, forwarding/FSM enums and the shadow entry type for pipe_ctrl
package pipe_ctrl_pkg;

    localparam int STG_PC    = 0;
    localparam int STG_IFID  = 1;
    localparam int STG_IDEX  = 2;
    localparam int STG_EXMEM = 3;
    localparam int STG_MEMWB = 4;

    // widest register index a shadow entry can hold; narrower indices are zero-extended
    localparam int RD_MAX_W = 8;

    typedef enum logic [1:0] {
        FWD_REG   = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_t;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic                valid;
        logic [RD_MAX_W-1:0] rd;
        logic                reg_wr;
        logic                rd_mem;
    } shadow_ent_t;

    // an in-flight writer produces the value a reader needs; x0 is never a real dependency
    function automatic logic ent_match(shadow_ent_t e, logic [RD_MAX_W-1:0] rs, logic used);
        return e.valid & e.reg_wr & (e.rd != '0) & (e.rd == rs) & used;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: ID decode, branch and data-memory status in, pipeline controls out; fwd selects exist with PIPE_CTRL_FWD_EN
interface pipe_ctrl_if #(
    parameter int REG_IDX_W = 5,
    parameter int CNT_W     = 32
);
    import pipe_ctrl_pkg::*;

    logic                 id_valid;
    logic [REG_IDX_W-1:0] id_rs1_idx;
    logic [REG_IDX_W-1:0] id_rs2_idx;
    logic                 id_rs1_used;
    logic                 id_rs2_used;
    logic [REG_IDX_W-1:0] id_rd_idx;
    logic                 id_reg_wr;
    logic                 id_rd_mem;
    logic                 br_taken;
    logic                 mem_req;
    logic                 mem_ready;
    logic [4:0]           stage_en;
    logic [4:0]           stage_clr;
`ifdef PIPE_CTRL_FWD_EN
    fwd_sel_t             fwd_a_sel;
    fwd_sel_t             fwd_b_sel;
`endif
    logic                 mem_timeout;
    logic [CNT_W-1:0]     stall_cnt;
    logic [CNT_W-1:0]     flush_cnt;

    modport master (
`ifdef PIPE_CTRL_FWD_EN
        input  fwd_a_sel, fwd_b_sel,
`endif
        output id_valid, id_rs1_idx, id_rs2_idx, id_rs1_used, id_rs2_used,
               id_rd_idx, id_reg_wr, id_rd_mem, br_taken, mem_req, mem_ready,
        input  stage_en, stage_clr, mem_timeout, stall_cnt, flush_cnt
    );

    modport slave (
`ifdef PIPE_CTRL_FWD_EN
        output fwd_a_sel, fwd_b_sel,
`endif
        input  id_valid, id_rs1_idx, id_rs2_idx, id_rs1_used, id_rs2_used,
               id_rd_idx, id_reg_wr, id_rd_mem, br_taken, mem_req, mem_ready,
        output stage_en, stage_clr, mem_timeout, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipe_ctrl_scoreboard.sv
// pipe_ctrl_scoreboard: shadow of the ID/EX, EX/MEM, MEM/WB writers and their source-match vectors (EX-side matches with PIPE_CTRL_FWD_EN)
module pipe_ctrl_scoreboard
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_IDX_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           stage_en,
    input  logic [4:0]           stage_clr,
    input  logic                 id_valid,
    input  logic [REG_IDX_W-1:0] id_rs1_idx,
    input  logic [REG_IDX_W-1:0] id_rs2_idx,
    input  logic                 id_rs1_used,
    input  logic                 id_rs2_used,
    input  logic [REG_IDX_W-1:0] id_rd_idx,
    input  logic                 id_reg_wr,
    input  logic                 id_rd_mem,
`ifdef PIPE_CTRL_FWD_EN
    output logic                 idex_load,
    output logic [2:1]           ex_rs1_hit,
    output logic [2:1]           ex_rs2_hit,
`endif
    output logic [2:0]           rs1_hit,
    output logic [2:0]           rs2_hit
);

    shadow_ent_t ent [3];
    shadow_ent_t src [3];

    // each entry loads from the one upstream of it; ID/EX loads the decoded instruction
    always_comb begin
        src[0] = '{id_valid, RD_MAX_W'(id_rd_idx), id_reg_wr, id_rd_mem};
        src[1] = ent[0];
        src[2] = ent[1];
    end

    // entries advance and bubble on the very controls driven to the real pipeline registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            ent <= '{default: '0};
        end else begin
            for (int i = 0; i < 3; i++)
                if (stage_clr[STG_IDEX+i]) ent[i] <= '0;
                else if (stage_en[STG_IDEX+i]) ent[i] <= src[i];
        end
    end

    // ID-stage sources against every in-flight writer
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            rs1_hit[i] = id_valid & ent_match(ent[i], RD_MAX_W'(id_rs1_idx), id_rs1_used);
            rs2_hit[i] = id_valid & ent_match(ent[i], RD_MAX_W'(id_rs2_idx), id_rs2_used);
        end
    end

`ifdef PIPE_CTRL_FWD_EN
    logic [RD_MAX_W-1:0] ex_rs1, ex_rs2;
    logic                ex_u1, ex_u2;

    assign idex_load = ent[0].rd_mem;

    // the EX instruction's sources ride along with the ID/EX entry for the forwarding compare
    always_ff @(posedge clk) begin
        if (!rst) begin
            {ex_rs1, ex_rs2, ex_u1, ex_u2} <= '0;
        end else if (stage_en[STG_IDEX] && !stage_clr[STG_IDEX]) begin
            ex_rs1 <= RD_MAX_W'(id_rs1_idx);
            ex_rs2 <= RD_MAX_W'(id_rs2_idx);
            ex_u1  <= id_rs1_used;
            ex_u2  <= id_rs2_used;
        end
    end

    // EX-stage sources against the two older writers that can forward
    always_comb begin
        for (int i = 1; i < 3; i++) begin
            ex_rs1_hit[i] = ent[0].valid & ent_match(ent[i], ex_rs1, ex_u1);
            ex_rs2_hit[i] = ent[0].valid & ent_match(ent[i], ex_rs2, ex_u2);
        end
    end
`endif

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush/bubble control for the 5-stage RV32 pipeline; PIPE_CTRL_FWD_EN adds EX operand forwarding
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_IDX_W   = 5,
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 0
) (
    input logic        clk,
    input logic        rst,
    pipe_ctrl_if.slave bus
);

    mem_state_t       state, state_nxt;
    logic [31:0]      wait_cnt, wait_cnt_nxt, cnt_now;
    logic             raw_wait, tmo_hit, mem_wait, hazard;
    logic             stall_evt, flush_evt;
    logic [2:0]       rs1_hit, rs2_hit;
    logic [CNT_W-1:0] stall_q, flush_q;

`ifdef PIPE_CTRL_FWD_EN
    logic       idex_load;
    logic [2:1] ex_rs1_hit, ex_rs2_hit;
`endif

    pipe_ctrl_scoreboard #(.REG_IDX_W(REG_IDX_W)) u_sb (
        .clk         (clk),
        .rst         (rst),
        .stage_en    (bus.stage_en),
        .stage_clr   (bus.stage_clr),
        .id_valid    (bus.id_valid),
        .id_rs1_idx  (bus.id_rs1_idx),
        .id_rs2_idx  (bus.id_rs2_idx),
        .id_rs1_used (bus.id_rs1_used),
        .id_rs2_used (bus.id_rs2_used),
        .id_rd_idx   (bus.id_rd_idx),
        .id_reg_wr   (bus.id_reg_wr),
        .id_rd_mem   (bus.id_rd_mem),
`ifdef PIPE_CTRL_FWD_EN
        .idex_load   (idex_load),
        .ex_rs1_hit  (ex_rs1_hit),
        .ex_rs2_hit  (ex_rs2_hit),
`endif
        .rs1_hit     (rs1_hit),
        .rs2_hit     (rs2_hit)
    );

    // memory wait: the first unready cycle counts as wait cycle 1, so a timeout of N releases on the N-th
    always_comb begin
        cnt_now      = (state == MEM_IDLE) ? 32'd1 : wait_cnt;
        raw_wait     = (state == MEM_IDLE) ? (bus.mem_req & ~bus.mem_ready) : ~bus.mem_ready;
        tmo_hit      = (MEM_TIMEOUT != 0) && raw_wait && (cnt_now == 32'(MEM_TIMEOUT));
        mem_wait     = raw_wait & ~tmo_hit;
        state_nxt    = mem_wait ? MEM_WAIT : MEM_IDLE;
        wait_cnt_nxt = mem_wait ? cnt_now + 32'd1 : 32'd0;
    end

    // memory FSM state and wait counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= MEM_IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

`ifdef PIPE_CTRL_FWD_EN
    assign hazard = idex_load & (rs1_hit[0] | rs2_hit[0]);
`else
    assign hazard = |{rs1_hit, rs2_hit};
`endif

    // priority: memory wait freezes everything, a branch discards the younger slots, a hazard bubbles ID/EX
    always_comb begin
        bus.stage_en  = 5'b11111;
        bus.stage_clr = 5'b00000;
        stall_evt     = 1'b0;
        flush_evt     = 1'b0;
        if (!rst) begin
            bus.stage_en  = 5'b00000;
            bus.stage_clr = 5'b11111;
        end else if (mem_wait) begin
            bus.stage_en  = 5'b10000;
            bus.stage_clr = 5'b10000;
            stall_evt     = 1'b1;
        end else if (bus.br_taken) begin
            bus.stage_clr = 5'b01110;
            flush_evt     = 1'b1;
        end else if (hazard) begin
            bus.stage_en  = 5'b11100;
            bus.stage_clr = 5'b00100;
            stall_evt     = 1'b1;
        end
    end

    assign bus.mem_timeout = rst & tmo_hit;

    // saturating performance counters
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (stall_evt && stall_q != '1) stall_q <= stall_q + 1'b1;
            if (flush_evt && flush_q != '1) flush_q <= flush_q + 1'b1;
        end
    end

    assign bus.stall_cnt = stall_q;
    assign bus.flush_cnt = flush_q;

`ifdef PIPE_CTRL_FWD_EN
    // the EX/MEM result is newer than MEM/WB, so it wins when both hold the source
    always_comb begin
        bus.fwd_a_sel = !rst ? FWD_REG : ex_rs1_hit[1] ? FWD_EXMEM : ex_rs1_hit[2] ? FWD_MEMWB : FWD_REG;
        bus.fwd_b_sel = !rst ? FWD_REG : ex_rs2_hit[1] ? FWD_EXMEM : ex_rs2_hit[2] ? FWD_MEMWB : FWD_REG;
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed + randomized scoreboard bench for pipe_ctrl against a pipeline-occupancy model
module tb_pipe_ctrl;

    localparam int RW  = 5;
    localparam int CW  = 4;
    localparam int TMO = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pipe_ctrl_if #(.REG_IDX_W(RW), .CNT_W(CW)) bus ();

    pipe_ctrl #(.REG_IDX_W(RW), .CNT_W(CW), .MEM_TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit v;
        int rd;
        bit wr;
        bit ld;
        int rs1;
        bit u1;
        int rs2;
        bit u2;
    } ins_t;

    typedef struct {
        logic [4:0] en;
        logic [4:0] clr;
        bit         tmo;
        int         sc;
        int         fc;
        int         fa;
        int         fb;
    } exp_t;

    exp_t q[$];
    exp_t m;
    ins_t pipe [3];
    int   waited  = 0;
    int   stalls  = 0;
    int   flushes = 0;
    int   n_cmp   = 0;
    int   n_bad   = 0;

    function automatic ins_t mk(bit v, int rd, bit wr, bit ld, int rs1, bit u1, int rs2, bit u2);
        ins_t r;
        r.v = v; r.rd = rd; r.wr = wr; r.ld = ld;
        r.rs1 = rs1; r.u1 = u1; r.rs2 = rs2; r.u2 = u2;
        return r;
    endfunction

    function automatic bit needs(ins_t w, int rs, bit used, bit reader_valid);
        return reader_valid && used && w.v && w.wr && w.rd != 0 && w.rd == rs;
    endfunction

    function automatic int sat_inc(int x);
        return (x < (1 << CW) - 1) ? x + 1 : x;
    endfunction

    function void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    // one clock: drive inputs, predict this cycle's controls, then move the modelled instructions
    task automatic step(input bit rn, input ins_t id, input bit br, input bit req, input bit rdy, output bit took);
        exp_t e;
        bit   hold, tmo, haz;
        ins_t bubble;
        bubble = mk(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst             = rn;
        bus.id_valid    = id.v;
        bus.id_rd_idx   = RW'(id.rd);
        bus.id_reg_wr   = id.wr;
        bus.id_rd_mem   = id.ld;
        bus.id_rs1_idx  = RW'(id.rs1);
        bus.id_rs1_used = id.u1;
        bus.id_rs2_idx  = RW'(id.rs2);
        bus.id_rs2_used = id.u2;
        bus.br_taken    = br;
        bus.mem_req     = req;
        bus.mem_ready   = rdy;
        e.sc = stalls; e.fc = flushes; e.fa = 0; e.fb = 0; e.tmo = 0;
        took = 0;
        if (!rn) begin
            e.en = 5'b00000; e.clr = 5'b11111;
            foreach (pipe[i]) pipe[i] = bubble;
            waited = 0; stalls = 0; flushes = 0;
            q.push_back(e);
            return;
        end
        hold = (req || waited > 0) && !rdy;
        tmo  = hold && TMO != 0 && waited + 1 == TMO;
        if (tmo) hold = 0;
        waited = hold ? waited + 1 : 0;
        e.tmo = tmo;
`ifdef PIPE_CTRL_FWD_EN
        haz = pipe[0].ld && (needs(pipe[0], id.rs1, id.u1, id.v) || needs(pipe[0], id.rs2, id.u2, id.v));
        e.fa = needs(pipe[1], pipe[0].rs1, pipe[0].u1, pipe[0].v) ? 1 : needs(pipe[2], pipe[0].rs1, pipe[0].u1, pipe[0].v) ? 2 : 0;
        e.fb = needs(pipe[1], pipe[0].rs2, pipe[0].u2, pipe[0].v) ? 1 : needs(pipe[2], pipe[0].rs2, pipe[0].u2, pipe[0].v) ? 2 : 0;
`else
        haz = 0;
        foreach (pipe[i]) haz |= needs(pipe[i], id.rs1, id.u1, id.v) || needs(pipe[i], id.rs2, id.u2, id.v);
`endif
        if (hold) begin
            e.en = 5'b10000; e.clr = 5'b10000;
            stalls = sat_inc(stalls);
            pipe[2] = bubble;
        end else if (br) begin
            e.en = 5'b11111; e.clr = 5'b01110;
            flushes = sat_inc(flushes);
            pipe[2] = pipe[1]; pipe[1] = bubble; pipe[0] = bubble;
            took = 1;
        end else if (haz) begin
            e.en = 5'b11100; e.clr = 5'b00100;
            stalls = sat_inc(stalls);
            pipe[2] = pipe[1]; pipe[1] = pipe[0]; pipe[0] = bubble;
        end else begin
            e.en = 5'b11111; e.clr = 5'b00000;
            pipe[2] = pipe[1]; pipe[1] = pipe[0]; pipe[0] = id;
            took = 1;
        end
        q.push_back(e);
    endtask

    // present an instruction in ID until it leaves (bounded)
    task automatic issue(input ins_t id);
        bit took;
        took = 0;
        for (int n = 0; n < 8 && !took; n++) step(1'b1, id, 1'b0, 1'b0, 1'b1, took);
    endtask

    // monitor: every cycle the DUT presents a control word, checked against the oldest prediction
    initial begin
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                m = q.pop_front();
                chk("stage_en", 32'(bus.stage_en), 32'(m.en));
                chk("stage_clr", 32'(bus.stage_clr), 32'(m.clr));
                chk("mem_timeout", 32'(bus.mem_timeout), 32'(m.tmo));
                chk("stall_cnt", 32'(bus.stall_cnt), m.sc);
                chk("flush_cnt", 32'(bus.flush_cnt), m.fc);
`ifdef PIPE_CTRL_FWD_EN
                chk("fwd_a_sel", 32'(bus.fwd_a_sel), m.fa);
                chk("fwd_b_sel", 32'(bus.fwd_b_sel), m.fb);
`endif
            end
        end
    end

    initial begin
        ins_t nop, cur;
        bit   t;
        nop = mk(0, 0, 0, 0, 0, 0, 0, 0);
        bus.id_valid = 0; bus.id_rd_idx = 0; bus.id_reg_wr = 0; bus.id_rd_mem = 0;
        bus.id_rs1_idx = 0; bus.id_rs1_used = 0; bus.id_rs2_idx = 0; bus.id_rs2_used = 0;
        bus.br_taken = 0; bus.mem_req = 0; bus.mem_ready = 0;
        repeat (2) step(1'b0, nop, 1'b0, 1'b0, 1'b0, t);
        // load-use: lw x5 then add x6,x5,x1
        issue(mk(1, 5, 1, 1, 2, 1, 0, 0));
        issue(mk(1, 6, 1, 0, 5, 1, 1, 1));
        repeat (3) issue(nop);
        // x0 writer then x0 reader
        issue(mk(1, 0, 1, 0, 3, 1, 0, 0));
        issue(mk(1, 7, 1, 0, 0, 1, 0, 1));
        repeat (3) issue(nop);
        // branch with no wait
        step(1'b1, nop, 1'b1, 1'b0, 1'b1, t);
        // memory wait of 3 cycles
        repeat (3) step(1'b1, nop, 1'b0, 1'b1, 1'b0, t);
        step(1'b1, nop, 1'b0, 1'b1, 1'b1, t);
        // branch held through a wait, acting on release
        repeat (2) step(1'b1, nop, 1'b1, 1'b1, 1'b0, t);
        step(1'b1, nop, 1'b1, 1'b1, 1'b1, t);
        // timeout with ready never asserted
        repeat (4) step(1'b1, nop, 1'b0, 1'b1, 1'b0, t);
        step(1'b1, nop, 1'b0, 1'b0, 1'b0, t);
        // reset mid-wait with a writer in flight, then its reader must not stall
        issue(mk(1, 9, 1, 1, 0, 0, 0, 0));
        repeat (2) step(1'b1, nop, 1'b0, 1'b1, 1'b0, t);
        step(1'b0, nop, 1'b0, 1'b1, 1'b0, t);
        issue(mk(1, 10, 1, 0, 9, 1, 9, 1));
        step(1'b1, nop, 1'b0, 1'b0, 1'b1, t);
        // flush counter saturation
        repeat (18) step(1'b1, nop, 1'b1, 1'b0, 1'b1, t);
        // randomized traffic with a small register space for frequent dependencies
        cur = nop;
        for (int k = 0; k < 3000; k++) begin
            step($urandom_range(0, 199) != 0, cur, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 0, t);
            if (t) cur = mk($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3) != 0,
                            $urandom_range(0, 2) == 0, $urandom_range(0, 3), $urandom_range(0, 1) == 1,
                            $urandom_range(0, 3), $urandom_range(0, 1) == 1);
        end
        step(1'b1, nop, 1'b0, 1'b0, 1'b1, t);
        repeat (2) @(negedge clk);
        chk("scoreboard_drain", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
